ccff_chain_loader: RTL

Configuration-chain driver that sits directly upstream of the routing/logic tiles' configuration flip-flop chain and drives the first tile's `ccff_head`. It takes bitstream words from the PMU over a valid/ready handshake and serialises them MSB-first into the chain, one bit per enabled `prog_clk` cycle. It also produces the enable for the external chain clock gate and counts the ones that leave the chain end (`ccff_tail`). That count is the readback check that the previous content was zeroised.

---
 rtl/ccff_pkg.sv | 12 +
 rtl/ccff_chain_loader.sv | 105 ++++++++++
 2 files changed

// File: rtl/ccff_pkg.sv
// Shared types for the configuration-chain loader.
package ccff_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } ccff_state_e;

    localparam int CCFF_WORD_W = 32;

endpackage

// File: rtl/ccff_chain_loader.sv
// Serialises PMU bitstream words MSB-first into the configuration flop chain,
// gates the chain clock and counts ones leaving the chain tail.
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = CCFF_WORD_W,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              chain_shift_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  tail_ones
);

    localparam int WB_W = $clog2(WORD_W + 1);
    localparam int CW   = ((CNT_W > WB_W) ? CNT_W : WB_W) + 1;

    ccff_state_e       state;
    ccff_state_e       state_nxt;
    logic [CNT_W-1:0]  bits_left;
    logic [WB_W-1:0]   wbits;
    logic [WORD_W-1:0] sreg;
    logic              take;
    logic              enter_load;
    logic              last_bit;

    // Bits worth shifting from the next word: a full word, or only what the chain still needs.
    function automatic logic [WB_W-1:0] word_fill(input logic [CW-1:0] remain);
        if (remain >= CW'(WORD_W)) begin
            return WB_W'(WORD_W);
        end
        return WB_W'(remain);
    endfunction

    assign chain_shift_en = (state == LOAD) && (wbits != '0);
    assign ccff_head      = chain_shift_en & sreg[WORD_W-1];
    assign word_ready     = (state == LOAD) && (CW'(bits_left) > CW'(wbits)) &&
                            ((wbits == '0) || ((wbits == WB_W'(1)) && chain_shift_en));
    assign take           = word_valid && word_ready;
    assign last_bit       = chain_shift_en && (bits_left == CNT_W'(1));
    assign enter_load     = start && ((state == IDLE) || (state == DONE));
    assign busy           = (state == LOAD);
    assign done           = (state == DONE);

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (last_bit) state_nxt = DONE;
            DONE:    if (start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    // A reload on the last bit of a word wins over that word's decrement.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            bits_left <= '0;
            wbits     <= '0;
            tail_ones <= '0;
        end else if (enter_load) begin
            bits_left <= CNT_W'(CHAIN_LEN);
            wbits     <= '0;
            tail_ones <= '0;
        end else begin
            if (chain_shift_en) begin
                bits_left <= bits_left - CNT_W'(1);
                if (ccff_tail) begin
                    tail_ones <= tail_ones + CNT_W'(1);
                end
            end
            if (take) begin
                wbits <= word_fill(CW'(bits_left) - CW'(wbits));
            end else if (chain_shift_en) begin
                wbits <= wbits - WB_W'(1);
            end
        end
    end

    always_ff @(posedge prog_clk) begin
        if (take) begin
            sreg <= word_data;
        end else if (chain_shift_en) begin
            sreg <= {sreg[WORD_W-2:0], 1'b0};
        end
    end

endmodule
